pc_sequencer: RTL and testbench

- Parametrised program-counter sequencer for the single-cycle RISC-V datapath. It replaces the free-running PC register and next-PC muxing in the core top level.
- Adds the following behaviour:
  - configurable PC width and reset vector
  - multi-cycle fetch wait for synchronous ROMs
  - explicit halt on illegal opcode or misaligned target
  - single-step debug mode
  - retired-instruction counter
- Sits between instruction ROM, immediate generator and ALU; drives the ROM address and the link value written back on JAL/JALR.

---
 rtl/pc_sequencer.sv | 145 ++++++++++++++
 tb/tb_pc_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch wait, next-PC selection, halt on fault,
// single-step pause and retired-instruction counting.
module pc_sequencer #(
  parameter int unsigned PC_W      = 11,
  parameter int unsigned RESET_PC  = 0,
  parameter int unsigned FETCH_LAT = 1,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             funct3_0,
  input  logic             alu_zero,
  input  logic [PC_W-1:0]  alu_y,
  input  logic [PC_W-1:0]  imm,
  input  logic             step_mode,
  input  logic             step,
  input  logic             resume,
  output logic [PC_W-1:0]  pc,
  output logic [31:0]      link,
  output logic             commit,
  output logic             halted,
  output logic [1:0]       fault,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_PAUSE, ST_HALT} state_e;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_L    = 7'b0000011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [PC_W-1:0] PC_RST  = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);
  localparam logic [2:0]      LAT     = 3'(FETCH_LAT);

  state_e             state_q, state_d;
  logic [2:0]         wait_q, wait_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [CNT_W-1:0]   instret_q, instret_d;
  logic [1:0]         fault_q, fault_d;
  logic               halted_q, halted_d;

  logic [PC_W-1:0]    pc_plus4;
  logic [PC_W-1:0]    target;
  logic               legal;
  logic               taken;
  logic               commit_now;

  // JALR forces bit0 low, so alu_y[0] never reaches the PC.
  logic               unused_alu_y0;
  assign unused_alu_y0 = alu_y[0];

  always_comb begin
    pc_plus4   = pc_q + PC_STEP;
    legal      = opcode inside {OP_R, OP_I, OP_S, OP_L, OP_BR, OP_JAL, OP_JALR};
    taken      = (opcode == OP_JAL) || ((opcode == OP_BR) && (funct3_0 ^ alu_zero));
    if (opcode == OP_JALR)
      target = {alu_y[PC_W-1:1], 1'b0};
    else if (taken)
      target = pc_q + imm;
    else
      target = pc_plus4;

    state_d    = state_q;
    wait_d     = wait_q;
    pc_d       = pc_q;
    instret_d  = instret_q;
    fault_d    = fault_q;
    commit_now = 1'b0;

    case (state_q)
      ST_FETCH: begin
        wait_d = wait_q - 3'd1;
        if (wait_q == 3'd1) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (!legal) begin
          state_d = ST_HALT;
          fault_d = 2'b01;
        end else if (target[1]) begin
          state_d = ST_HALT;
          fault_d = 2'b10;
        end else begin
          commit_now = 1'b1;
          pc_d       = target;
          instret_d  = instret_q + CNT_W'(1);
          state_d    = step_mode ? ST_PAUSE : ST_FETCH;
          wait_d     = LAT;
        end
      end
      ST_PAUSE: begin
        if (step || !step_mode) begin
          state_d = ST_FETCH;
          wait_d  = LAT;
        end
      end
      ST_HALT: begin
        if (resume) begin
          fault_d = 2'b00;
          pc_d    = pc_plus4;
          state_d = ST_FETCH;
          wait_d  = LAT;
        end
      end
      default: begin
        state_d = ST_FETCH;
        wait_d  = LAT;
      end
    endcase

    halted_d = (state_d == ST_HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      wait_q    <= LAT;
      pc_q      <= PC_RST;
      instret_q <= '0;
      fault_q   <= '0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      pc_q      <= pc_d;
      instret_q <= instret_d;
      fault_q   <= fault_d;
      halted_q  <= halted_d;
    end
  end

  // commit depends on the opcode presented during EXEC, so it cannot be a flop.
  assign commit  = commit_now;
  assign pc      = pc_q;
  assign link    = 32'(pc_plus4);
  assign halted  = halted_q;
  assign fault   = fault_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a randomized
// instruction stream checked against an arithmetic next-PC model.
module tb_pc_sequencer;

  localparam int PCW  = 11;
  localparam int MODV = 2 ** PCW;
  localparam int LAT1 = 1;
  localparam int LAT3 = 3;
  localparam logic [10:0] RST3_PC = 11'h100;

  localparam logic [6:0] OP_ADD  = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  logic        clk = 1'b0;
  logic        rst, rst3;
  logic [6:0]  opcode;
  logic        funct3_0, alu_zero;
  logic [10:0] alu_y, imm;
  logic        step_mode, step, resume;

  logic [10:0] pc1, pc3;
  logic [31:0] link1, link3, instret1, instret3;
  logic        commit1, commit3, halted1, halted3;
  logic [1:0]  fault1, fault3;

  int total = 0;
  int bad   = 0;
  logic [10:0] exp_pc;
  int exp_ret;

  always #5 clk = ~clk;

  pc_sequencer #(.PC_W(PCW), .RESET_PC(0), .FETCH_LAT(LAT1), .CNT_W(32)) u_dut1 (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3_0(funct3_0), .alu_zero(alu_zero),
    .alu_y(alu_y), .imm(imm), .step_mode(step_mode), .step(step), .resume(resume),
    .pc(pc1), .link(link1), .commit(commit1), .halted(halted1), .fault(fault1),
    .instret(instret1)
  );

  pc_sequencer #(.PC_W(PCW), .RESET_PC(32'h100), .FETCH_LAT(LAT3), .CNT_W(32)) u_dut3 (
    .clk(clk), .rst(rst3), .opcode(opcode), .funct3_0(funct3_0), .alu_zero(alu_zero),
    .alu_y(alu_y), .imm(imm), .step_mode(step_mode), .step(step), .resume(resume),
    .pc(pc3), .link(link3), .commit(commit3), .halted(halted3), .fault(fault3),
    .instret(instret3)
  );

  // Reference: next PC and fault code from the instruction rules, plain integer math.
  function automatic void ref_exec(input int pc, input logic [6:0] op, input logic f3,
                                   input logic z, input int ay, input int im,
                                   output int nxt, output int flt);
    int tgt;
    case (op)
      OP_BR:   tgt = (f3 ^ z) ? (pc + im) % MODV : (pc + 4) % MODV;
      OP_JAL:  tgt = (pc + im) % MODV;
      OP_JALR: tgt = (ay / 2) * 2;
      OP_ADD, OP_ADDI, OP_SW, OP_LW: tgt = (pc + 4) % MODV;
      default: tgt = -1;
    endcase
    if (tgt < 0) begin
      flt = 1; nxt = pc;
    end else if ((tgt / 2) % 2 == 1) begin
      flt = 2; nxt = pc;
    end else begin
      flt = 0; nxt = tgt;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_wait(output int commits);
    commits = 0;
    for (int i = 0; i < LAT1; i++) begin
      if (commit1) commits++;
      tick();
    end
  endtask

  // Drives one instruction into dut1 from a fresh FETCH and observes EXEC and the edge after it.
  task automatic exec_one(input logic [6:0] op, input logic f3, input logic z,
                          input logic [10:0] ay, input logic [10:0] im,
                          output int c_fetch, output logic c_exec, output logic [31:0] lnk,
                          output logic [10:0] pc_exec, output logic [10:0] pc_after,
                          output logic [1:0] flt, output logic hlt, output logic [31:0] ret);
    opcode = op; funct3_0 = f3; alu_zero = z; alu_y = ay; imm = im;
    fetch_wait(c_fetch);
    c_exec = commit1; lnk = link1; pc_exec = pc1;
    tick();
    pc_after = pc1; flt = fault1; hlt = halted1; ret = instret1;
  endtask

  task automatic pulse_resume();
    resume = 1'b1; tick(); resume = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst3 = 1'b1;
    #1;
    total++; if (pc1 !== 11'h000) begin bad++; $display("FAIL reset_pc got=%0h want=0", pc1); end
    total++; if (commit1 !== 1'b0 || halted1 !== 1'b0) begin bad++; $display("FAIL reset_flags commit=%0b halted=%0b want=0", commit1, halted1); end
    total++; if (fault1 !== 2'b00 || instret1 !== 32'd0) begin bad++; $display("FAIL reset_fault_cnt fault=%0b instret=%0d want=0", fault1, instret1); end
    tick(); tick();
    rst = 1'b0;
    exp_pc = 11'h000; exp_ret = 0;
  endtask

  task automatic test_sequential();
    int cf; logic ce, hl; logic [31:0] lk, rt; logic [10:0] pe, pa; logic [1:0] fl;
    for (int k = 0; k < 3; k++) begin
      exec_one(OP_ADDI, 1'($urandom), 1'($urandom), 11'($urandom), 11'($urandom), cf, ce, lk, pe, pa, fl, hl, rt);
      total++; if (cf !== 0 || ce !== 1'b1) begin bad++; $display("FAIL seq_cadence k=%0d fetch_commits=%0d exec_commit=%0b want 0/1", k, cf, ce); end
      total++; if (pe !== exp_pc || lk !== 32'(exp_pc) + 32'd4) begin bad++; $display("FAIL seq_pc_link k=%0d pc=%0h link=%0h want pc=%0h", k, pe, lk, exp_pc); end
      exp_pc = exp_pc + 11'd4; exp_ret++;
    end
    total++; if (pc1 !== 11'h00C || instret1 !== 32'd3) begin bad++; $display("FAIL seq_end pc=%0h instret=%0d want 00c/3", pc1, instret1); end
  endtask

  task automatic test_branch();
    int cf, nxt, flt; logic ce, hl, f3, z; logic [31:0] lk, rt; logic [10:0] pe, pa, im; logic [1:0] fl;
    exec_one(OP_ADDI, 1'b0, 1'b0, 11'h0, 11'h0, cf, ce, lk, pe, pa, fl, hl, rt);
    exp_pc = 11'h010; exp_ret++;
    exec_one(OP_BR, 1'b0, 1'b1, 11'($urandom), 11'h7F8, cf, ce, lk, pe, pa, fl, hl, rt);
    total++; if (ce !== 1'b1 || pa !== 11'h008) begin bad++; $display("FAIL beq_taken commit=%0b pc=%0h want 1/008", ce, pa); end
    exec_one(OP_BR, 1'b1, 1'b1, 11'($urandom), 11'h7F8, cf, ce, lk, pe, pa, fl, hl, rt);
    total++; if (ce !== 1'b1 || pa !== 11'h00C) begin bad++; $display("FAIL bne_not_taken commit=%0b pc=%0h want 1/00c", ce, pa); end
    exp_pc = 11'h00C; exp_ret += 2;
    for (int k = 0; k < 8; k++) begin
      f3 = 1'($urandom); z = 1'($urandom); im = 11'($urandom_range(0, 511) * 4);
      ref_exec(int'(exp_pc), OP_BR, f3, z, 0, int'(im), nxt, flt);
      exec_one(OP_BR, f3, z, 11'($urandom), im, cf, ce, lk, pe, pa, fl, hl, rt);
      total++; if (ce !== 1'b1 || pa !== 11'(nxt)) begin bad++; $display("FAIL branch_rand k=%0d f3=%0b z=%0b pc=%0h want=%0h", k, f3, z, pa, 11'(nxt)); end
      exp_pc = 11'(nxt); exp_ret++;
    end
  endtask

  task automatic test_jalr_misalign();
    int cf, holds, moved; logic ce, hl; logic [31:0] lk, rt; logic [10:0] pe, pa, im; logic [1:0] fl;
    im = 11'h040 - exp_pc;
    exec_one(OP_JAL, 1'b0, 1'b0, 11'h0, im, cf, ce, lk, pe, pa, fl, hl, rt);
    total++; if (pa !== 11'h040 || lk !== 32'(exp_pc) + 32'd4) begin bad++; $display("FAIL jal_to_40 pc=%0h link=%0h want 040/%0h", pa, lk, exp_pc + 11'd4); end
    exp_ret++;
    exec_one(OP_JALR, 1'b0, 1'b0, 11'h021, 11'($urandom), cf, ce, lk, pe, pa, fl, hl, rt);
    total++; if (pa !== 11'h020 || lk !== 32'h44 || ce !== 1'b1) begin bad++; $display("FAIL jalr_odd pc=%0h link=%0h commit=%0b want 020/44/1", pa, lk, ce); end
    exp_ret++;
    exec_one(OP_JAL, 1'b0, 1'b0, 11'h0, 11'h020, cf, ce, lk, pe, pa, fl, hl, rt);
    exp_ret++;
    exec_one(OP_JALR, 1'b0, 1'b0, 11'h022, 11'h0, cf, ce, lk, pe, pa, fl, hl, rt);
    total++; if (ce !== 1'b0 || hl !== 1'b1 || fl !== 2'b10) begin bad++; $display("FAIL jalr_misalign commit=%0b halted=%0b fault=%0b want 0/1/10", ce, hl, fl); end
    total++; if (pa !== 11'h040 || rt !== 32'(exp_ret)) begin bad++; $display("FAIL misalign_frozen pc=%0h instret=%0d want 040/%0d", pa, rt, exp_ret); end
    holds = 0; moved = 0; step = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (commit1) holds++;
      if (pc1 !== 11'h040 || halted1 !== 1'b1) moved++;
      tick();
    end
    step = 1'b0;
    total++; if (holds !== 0 || moved !== 0) begin bad++; $display("FAIL halt_hold commits=%0d changes=%0d want 0/0", holds, moved); end
    pulse_resume();
    total++; if (fault1 !== 2'b00 || halted1 !== 1'b0 || pc1 !== 11'h044) begin bad++; $display("FAIL misalign_resume fault=%0b halted=%0b pc=%0h want 00/0/044", fault1, halted1, pc1); end
    exp_pc = 11'h044;
  endtask

  task automatic test_illegal();
    int cf; logic ce, hl; logic [31:0] lk, rt; logic [10:0] pe, pa; logic [1:0] fl;
    resume = 1'b1;
    exec_one(OP_JAL, 1'b0, 1'b0, 11'h0, 11'h00C - exp_pc, cf, ce, lk, pe, pa, fl, hl, rt);
    resume = 1'b0;
    total++; if (pa !== 11'h00C || hl !== 1'b0) begin bad++; $display("FAIL resume_ignored pc=%0h halted=%0b want 00c/0", pa, hl); end
    exp_ret++;
    exec_one(7'b0000000, 1'b0, 1'b0, 11'h0, 11'h0, cf, ce, lk, pe, pa, fl, hl, rt);
    total++; if (ce !== 1'b0 || hl !== 1'b1 || fl !== 2'b01 || pa !== 11'h00C) begin bad++; $display("FAIL illegal commit=%0b halted=%0b fault=%0b pc=%0h want 0/1/01/00c", ce, hl, fl, pa); end
    pulse_resume();
    total++; if (fault1 !== 2'b00 || pc1 !== 11'h010) begin bad++; $display("FAIL illegal_resume fault=%0b pc=%0h want 00/010", fault1, pc1); end
    exec_one(OP_SW, 1'b0, 1'b0, 11'h0, 11'h0, cf, ce, lk, pe, pa, fl, hl, rt);
    exp_ret++;
    total++; if (ce !== 1'b1 || pa !== 11'h014 || rt !== 32'(exp_ret)) begin bad++; $display("FAIL after_resume commit=%0b pc=%0h instret=%0d want 1/014/%0d", ce, pa, rt, exp_ret); end
    exp_pc = 11'h014;
  endtask

  task automatic test_single_step();
    int cf, holds, moved; logic ce, hl; logic [31:0] lk, rt; logic [10:0] pe, pa; logic [1:0] fl;
    step_mode = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        step = 1'b1; tick();
        step = (k == 2);
      end
      exec_one(OP_ADD, 1'b0, 1'b0, 11'h0, 11'h0, cf, ce, lk, pe, pa, fl, hl, rt);
      step = 1'b0;
      exp_pc = exp_pc + 11'd4; exp_ret++;
      total++; if (cf !== 0 || ce !== 1'b1 || pa !== exp_pc) begin bad++; $display("FAIL step_commit k=%0d commit=%0b pc=%0h want 1/%0h", k, ce, pa, exp_pc); end
      holds = 0; moved = 0;
      for (int i = 0; i < 12; i++) begin
        if (commit1) holds++;
        if (pc1 !== exp_pc) moved++;
        tick();
      end
      total++; if (holds !== 0 || moved !== 0) begin bad++; $display("FAIL step_pause k=%0d commits=%0d pc_changes=%0d want 0/0", k, holds, moved); end
    end
    step_mode = 1'b0; tick();
    for (int k = 0; k < 2; k++) begin
      exec_one(OP_LW, 1'b0, 1'b0, 11'h0, 11'h0, cf, ce, lk, pe, pa, fl, hl, rt);
      exp_pc = exp_pc + 11'd4; exp_ret++;
      total++; if (cf !== 0 || ce !== 1'b1 || pa !== exp_pc) begin bad++; $display("FAIL step_mode_exit k=%0d commit=%0b pc=%0h want 1/%0h", k, ce, pa, exp_pc); end
    end
  endtask

  task automatic test_wrap();
    int cf; logic ce, hl; logic [31:0] lk, rt; logic [10:0] pe, pa; logic [1:0] fl;
    exec_one(OP_JAL, 1'b0, 1'b0, 11'h0, 11'h7FC - exp_pc, cf, ce, lk, pe, pa, fl, hl, rt);
    total++; if (pa !== 11'h7FC) begin bad++; $display("FAIL wrap_setup pc=%0h want 7fc", pa); end
    exec_one(OP_ADDI, 1'b0, 1'b0, 11'h0, 11'h0, cf, ce, lk, pe, pa, fl, hl, rt);
    exp_ret += 2;
    total++; if (ce !== 1'b1 || pa !== 11'h000 || rt !== 32'(exp_ret)) begin bad++; $display("FAIL wrap pc=%0h instret=%0d want 000/%0d", pa, rt, exp_ret); end
    exp_pc = 11'h000;
  endtask

  task automatic test_random();
    int cf, nxt, flt, sel; logic ce, hl, f3, z; logic [31:0] lk, rt; logic [10:0] pe, pa, ay, im; logic [1:0] fl;
    logic [6:0] ops [10];
    ops = '{OP_ADD, OP_ADDI, OP_SW, OP_LW, OP_BR, OP_BR, OP_JAL, OP_JALR, 7'b0110111, 7'b0010111};
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 9);
      f3 = 1'($urandom); z = 1'($urandom); ay = 11'($urandom);
      im = 11'($urandom) & 11'h7FC;
      if ($urandom_range(0, 3) == 0) im = im | 11'h002;
      ref_exec(int'(exp_pc), ops[sel], f3, z, int'(ay), int'(im), nxt, flt);
      exec_one(ops[sel], f3, z, ay, im, cf, ce, lk, pe, pa, fl, hl, rt);
      if (flt == 0) exp_ret++;
      total++;
      if (ce !== (flt == 0) || pa !== 11'(nxt) || fl !== 2'(flt) || hl !== (flt != 0) || rt !== 32'(exp_ret)) begin
        bad++;
        $display("FAIL rand k=%0d op=%b commit=%0b pc=%0h fault=%0b instret=%0d want %0b/%0h/%0d/%0d",
                 k, ops[sel], ce, pa, fl, rt, flt == 0, 11'(nxt), flt, exp_ret);
      end
      exp_pc = 11'(nxt);
      if (flt != 0) begin
        pulse_resume();
        exp_pc = exp_pc + 11'd4;
      end
    end
  endtask

  task automatic test_async_reset();
    int cf, c3;
    opcode = OP_ADDI;
    fetch_wait(cf);
    total++; if (commit1 !== 1'b1) begin bad++; $display("FAIL pre_reset_exec commit=%0b want 1", commit1); end
    #2 rst = 1'b1;
    #1;
    total++; if (commit1 !== 1'b0 || pc1 !== 11'h000 || instret1 !== 32'd0) begin bad++; $display("FAIL rst_mid_exec commit=%0b pc=%0h instret=%0d want 0/000/0", commit1, pc1, instret1); end
    tick(); rst = 1'b0;
    rst3 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      c3 = 0;
      for (int i = 0; i < LAT3; i++) begin
        if (commit3) c3++;
        tick();
      end
      total++; if (c3 !== 0 || commit3 !== 1'b1 || pc3 !== RST3_PC + 11'(4 * k)) begin bad++; $display("FAIL lat3_exec k=%0d fetch_commits=%0d commit=%0b pc=%0h want 0/1/%0h", k, c3, commit3, pc3, RST3_PC + 11'(4 * k)); end
      tick();
    end
    total++; if (pc3 !== 11'h108 || instret3 !== 32'd2) begin bad++; $display("FAIL lat3_count pc=%0h instret=%0d want 108/2", pc3, instret3); end
    tick();
    #2 rst3 = 1'b1;
    #1;
    total++; if (pc3 !== RST3_PC || instret3 !== 32'd0 || commit3 !== 1'b0) begin bad++; $display("FAIL rst_mid_fetch pc=%0h instret=%0d commit=%0b want 100/0/0", pc3, instret3, commit3); end
    c3 = 0;
    for (int i = 0; i < 4; i++) begin
      if (commit3 || pc3 !== RST3_PC) c3++;
      tick();
    end
    total++; if (c3 !== 0) begin bad++; $display("FAIL rst_hold activity=%0d want 0", c3); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    opcode = OP_ADDI; funct3_0 = 1'b0; alu_zero = 1'b0; alu_y = '0; imm = '0;
    step_mode = 1'b0; step = 1'b0; resume = 1'b0;
    test_reset();
    test_sequential();
    test_branch();
    test_jalr_misalign();
    test_illegal();
    test_single_step();
    test_wrap();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
